lif_neuron: RTL and testbench
=============================

// Module: lif_neuron
// PURPOSE
//  - Single leaky integrate-and-fire (LIF) neuron. This is the top of the TinyTapeout tile.
//  - ui_in is an unsigned input current. The 8-bit membrane potential is exposed on uo_out.
//  - A spike flag is exposed on uio_out[0]. Leak is a right shift; reset after a spike is by subtraction.
// PARAMETERS
//  WIDTH          8    membrane/current width (fixed by tile pins; only 8 is supported)
//  THRESHOLD      200  firing threshold; spike when state >= THRESHOLD
//  LEAK_SHIFT     1    leak = state >> LEAK_SHIFT (beta = 0.5)
//  REFRACT_CYCLES 2    refractory length; used only with LIF_REFRACTORY_EN
// PORTS
//  clk      in   1  sole clock, rising edge
//  rst_n    in   1  synchronous ACTIVE-HIGH reset (tile pin name kept; 1 = reset)
//  ena      in   1  tile select; ignored, neuron always runs
//  ui_in    in   8  input current, unsigned
//  uo_out   out  8  membrane potential state[7:0]
//  uio_in   in   8  unused, ignored
//  uio_out  out  8  {7'b0, spike}
//  uio_oe   out  8  constant 8'hFF (all outputs)
//  Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
//  - Single state register state[7:0]. Reset value: state = 0, so uo_out = 0 and uio_out = 0.
//  - uio_oe = 8'hFF at all times, including during reset.
//  - spike = (state >= THRESHOLD). It is combinational from the register; no extra latency.
//  - Each rising clk without reset:
//      sum  = ui_in + (state >> LEAK_SHIFT)   computed 9-bit
//      sat  = (sum > 255) ? 255 : sum         saturate, never wrap
//      next = spike ? ((sat >= THRESHOLD) ? sat - THRESHOLD : 0) : sat   floor at 0
//      state <= next
//  - Current sampled on cycle N is visible on uo_out after edge N+1 (1-cycle latency).
//  - Reset asserted mid-operation: state is 0 after the next edge, regardless of ui_in.
//  - No wrap-around anywhere. Boundary state == THRESHOLD spikes; THRESHOLD-1 does not.
//  - ena and uio_in have no effect.
// CONFIGURATION
//  - Macro LIF_REFRACTORY_EN:
//    - Defined: adds refr_cnt (clog2(REFRACT_CYCLES+1) bits, reset 0).
//      - When spike is high, refr_cnt <= REFRACT_CYCLES.
//      - Otherwise, while refr_cnt != 0, it decrements.
//      - While refr_cnt != 0 (and spike low), the current term is forced to 0: leak only.
//    - Undefined: no counter; ui_in is always integrated.
// STRUCTURE
//  - Package lif_pkg holds:
//    - the WIDTH, THRESHOLD, LEAK_SHIFT and REFRACT_CYCLES defaults;
//    - a membrane_t typedef (logic [7:0]);
//    - a sat_add function.
//  - One sub-module, lif_core: state register, next-state math, spike compare and optional refractory logic.
//  - The top only maps pins (uo_out, uio_out, uio_oe) onto lif_core.
// TESTING
//  - Reset: hold rst_n=1 for 2 clk with ui_in=8'hFF.
//    -> uo_out=0, uio_out=0, uio_oe=8'hFF; after release with ui_in=0, state stays 0 and never spikes.
//  - Subthreshold: ui_in=50 constant.
//    -> uo_out = 0,50,75,87,93,96,98,99,99... ; uio_out[0] stays 0.
//  - Single spike: ui_in=150.
//    -> uo_out = 0,150,225; spike=1 while state=225.
//    -> next state = 255-200 = 55; spike=0.
//  - Saturation: ui_in=255.
//    -> uo_out = 0,255,55,255,55... (sum saturates at 255, never wraps); spike high on every 255.
//  - Boundary/leak:
//    -> state=200 (spike=1) with ui_in=0 -> next=0.
//    -> state=199 with ui_in=0 -> no spike, next=99.
//  - Mid-run reset: pulse rst_n=1 for 1 cycle while state=225.
//    -> uo_out=0 and spike=0 after that edge.
//  - With LIF_REFRACTORY_EN, ui_in=255:
//    -> uo_out = 0,255,55,27,13 (2 leak-only cycles), then 255.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared parameters, membrane type and saturating adder for the LIF neuron tile.
// Optional build macro: LIF_REFRACTORY_EN (see lif_core).
package lif_pkg;
   localparam int WIDTH          = 8;
   localparam int THRESHOLD      = 200;
   localparam int LEAK_SHIFT     = 1;
   localparam int REFRACT_CYCLES = 2;
   localparam int REFR_W         = $clog2(REFRACT_CYCLES + 1);

   typedef logic [WIDTH-1:0] membrane_t;

   localparam membrane_t THRESH_M = membrane_t'(THRESHOLD);

   // Unsigned add clamped to all-ones; the membrane must never wrap.
   function automatic membrane_t sat_add(input membrane_t a, input membrane_t b);
      logic [WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   endfunction
endpackage

// File: rtl/lif_neuron_if.sv
// Neuron-side bundle: input current toward the core, membrane and spike back out.
interface lif_neuron_if;
   import lif_pkg::*;

   membrane_t current;
   membrane_t state;
   logic      spike;

   modport master (output current, input state, input spike);
   modport slave  (input current, output state, output spike);
endinterface

// File: rtl/lif_core.sv
// LIF neuron core: membrane register, leak/integrate/saturate math and reset-by-subtraction.
// LIF_REFRACTORY_EN adds a post-spike window where only leak is applied.
module lif_core
   import lif_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   lif_neuron_if.slave  bus
);

   membrane_t state_q, state_d;
   membrane_t current;
   membrane_t leak;
   membrane_t sat;
   logic      spike;

   assign spike = (state_q >= THRESH_M);
   assign leak  = state_q >> LEAK_SHIFT;
   assign sat   = sat_add(current, leak);

`ifdef LIF_REFRACTORY_EN
   logic [REFR_W-1:0] refr_q, refr_d;

   // A spike (re)arms the window; the current is gated only while it drains.
   always_comb begin
      refr_d  = refr_q;
      current = bus.current;
      if (spike) begin
         refr_d = REFR_W'(REFRACT_CYCLES);
      end else if (refr_q != '0) begin
         refr_d  = refr_q - REFR_W'(1);
         current = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) refr_q <= '0;
      else       refr_q <= refr_d;
   end
`else
   assign current = bus.current;
`endif

   always_comb begin
      state_d = sat;
      if (spike) state_d = (sat >= THRESH_M) ? sat - THRESH_M : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= '0;
      else       state_q <= state_d;
   end

   assign bus.state = state_q;
   assign bus.spike = spike;

endmodule

// File: rtl/lif_neuron.sv
// Tile top: maps TinyTapeout pins onto lif_core. rst_n is active-high (1 = reset).
// Optional build macro: LIF_REFRACTORY_EN.
module lif_neuron
   import lif_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   lif_neuron_if core_if ();

   assign core_if.current = ui_in;

   lif_core u_core (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (core_if.slave)
   );

   assign uo_out  = core_if.state;
   assign uio_out = {7'b0, core_if.spike};
   assign uio_oe  = 8'hFF;

   // ena and uio_in are tile pins with no function in this neuron.
   logic unused_pins;
   assign unused_pins = &{ena, uio_in};

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron against an arithmetic LIF reference model.
module tb_lif_neuron;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   lif_neuron_if tif ();

   lif_neuron dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (tif.current),
      .uo_out  (tif.state),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   assign tif.spike = uio_out[0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: membrane value and remaining refractory cycles.
   int ms = 0;
   int mr = 0;

   task automatic model_step(input int cur, input bit rst);
      int c;
      int s;
      bit spk;
      if (rst) begin
         ms = 0;
         mr = 0;
      end else begin
         spk = (ms >= 200);
         c   = cur;
`ifdef LIF_REFRACTORY_EN
         if (!spk && mr > 0) c = 0;
`endif
         s = c + ms / 2;
         if (s > 255) s = 255;
         if (spk) s = (s >= 200) ? s - 200 : 0;
`ifdef LIF_REFRACTORY_EN
         if (spk) mr = 2;
         else if (mr > 0) mr = mr - 1;
`endif
         ms = s;
      end
   endtask

   // One clock with given current and reset; checks all outputs against the model.
   task automatic cycle(input logic [7:0] cur, input logic rst, input string tag);
      tif.current = cur;
      rst_n       = rst;
      ena         = 1'($urandom);
      uio_in      = 8'($urandom);
      @(posedge clk);
      model_step(int'(cur), rst);
      #1;
      n_cmp++;
      if (tif.state !== 8'(ms)) begin
         n_err++;
         $display("FAIL %s uo_out: got %0d expected %0d", tag, tif.state, ms);
      end
      n_cmp++;
      if (uio_out !== {7'b0, (ms >= 200)}) begin
         n_err++;
         $display("FAIL %s uio_out: got %h expected %h", tag, uio_out, {7'b0, (ms >= 200)});
      end
      n_cmp++;
      if (uio_oe !== 8'hFF) begin
         n_err++;
         $display("FAIL %s uio_oe: got %h expected ff", tag, uio_oe);
      end
   endtask

   task automatic do_reset();
      cycle(8'hFF, 1'b1, "reset");
   endtask

   task automatic expect_state(input int exp_v, input bit exp_spk, input string tag);
      n_cmp++;
      if (tif.state !== 8'(exp_v) || tif.spike !== exp_spk) begin
         n_err++;
         $display("FAIL %s: got state=%0d spike=%0b expected state=%0d spike=%0b",
                  tag, tif.state, tif.spike, exp_v, exp_spk);
      end
   endtask

   task automatic test_reset();
      cycle(8'hFF, 1'b1, "reset_hold0");
      cycle(8'hFF, 1'b1, "reset_hold1");
      expect_state(0, 1'b0, "reset_value");
      for (int i = 0; i < 6; i++) begin
         cycle(8'h00, 1'b0, "reset_idle");
         expect_state(0, 1'b0, "reset_idle_zero");
      end
   endtask

   task automatic test_subthreshold();
      int exp_seq[8] = '{50, 75, 87, 93, 96, 98, 99, 99};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(8'd50, 1'b0, "subthr");
         expect_state(exp_seq[i], 1'b0, "subthr_seq");
      end
   endtask

   task automatic test_single_spike();
      do_reset();
      cycle(8'd150, 1'b0, "spike");
      expect_state(150, 1'b0, "spike_150");
      cycle(8'd150, 1'b0, "spike");
      expect_state(225, 1'b1, "spike_225");
      cycle(8'd150, 1'b0, "spike");
      expect_state(55, 1'b0, "spike_after");
   endtask

   task automatic test_saturation();
      do_reset();
      cycle(8'd255, 1'b0, "sat");
      expect_state(255, 1'b1, "sat_first");
      cycle(8'd255, 1'b0, "sat");
      expect_state(55, 1'b0, "sat_sub");
      for (int i = 0; i < 6; i++) cycle(8'd255, 1'b0, "sat_run");
   endtask

   task automatic test_boundary();
      do_reset();
      cycle(8'd200, 1'b0, "bnd200");
      expect_state(200, 1'b1, "bnd_at_thr");
      cycle(8'd0, 1'b0, "bnd200");
      expect_state(0, 1'b0, "bnd_floor");
      do_reset();
      cycle(8'd199, 1'b0, "bnd199");
      expect_state(199, 1'b0, "bnd_below_thr");
      cycle(8'd0, 1'b0, "bnd199");
      expect_state(99, 1'b0, "bnd_leak");
   endtask

   task automatic test_midrun_reset();
      do_reset();
      cycle(8'd150, 1'b0, "midrst");
      cycle(8'd150, 1'b0, "midrst");
      expect_state(225, 1'b1, "midrst_pre");
      cycle(8'd150, 1'b1, "midrst_pulse");
      expect_state(0, 1'b0, "midrst_post");
      cycle(8'd150, 1'b0, "midrst_resume");
      expect_state(150, 1'b0, "midrst_resume");
   endtask

`ifdef LIF_REFRACTORY_EN
   task automatic test_refractory();
      int exp_seq[5] = '{255, 55, 27, 13, 255};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         cycle(8'd255, 1'b0, "refr");
         expect_state(exp_seq[i], (exp_seq[i] >= 200), "refr_seq");
      end
   endtask
`endif

   task automatic test_random();
      logic [7:0] cur;
      logic       rst;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0:       cur = 8'($urandom_range(0, 40));
            1:       cur = 8'($urandom_range(180, 255));
            default: cur = 8'($urandom);
         endcase
         rst = ($urandom_range(0, 31) == 0);
         cycle(cur, rst, "random");
      end
   endtask

   initial begin
      rst_n       = 1'b1;
      ena         = 1'b0;
      uio_in      = 8'h00;
      tif.current = 8'hFF;
      test_reset();
      test_subthreshold();
      test_single_spike();
      test_saturation();
      test_boundary();
      test_midrun_reset();
`ifdef LIF_REFRACTORY_EN
      test_refractory();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
